alu_driver: RTL

Command-side front end for the team's 4-bit registered ALU (opcodes add/mul/sub/div, 5-bit result, one-cycle registered latency). It accepts operation commands over a valid/ready interface and drives the ALU's `oper`/`in1`/`in2` inputs. It captures the ALU result at the correct cycle and returns it over a valid/ready response interface. The result is checked against an internal golden model, with a mismatch flag and counters, so the block serves as both a datapath sequencer and an in-circuit self-checker.

---
 rtl/alu_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_driver.sv
// Command-side sequencer for a registered 4-bit ALU with an in-circuit golden-model checker.
// Accepts one command at a time, drives the ALU, captures its result two clocks after accept,
// and returns it with the expected value, a mismatch flag and running counters.
module alu_driver #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  // Command side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_oper,
  input  logic [3:0]       cmd_in1,
  input  logic [3:0]       cmd_in2,
  // ALU side
  output logic [1:0]       alu_oper,
  output logic [3:0]       alu_in1,
  output logic [3:0]       alu_in2,
  input  logic [4:0]       alu_out,
  // Response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_data,
  output logic [4:0]       rsp_expected,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e state_q, state_d;

  logic             accept;
  logic             capture;
  logic             complete;
  logic [4:0]       golden;
  logic [7:0]       product;

  logic [1:0]       alu_oper_q;
  logic [3:0]       alu_in1_q;
  logic [3:0]       alu_in2_q;
  logic [4:0]       rsp_data_q;
  logic [4:0]       rsp_expected_q;
  logic             rsp_mismatch_q;
  logic [CNT_W-1:0] txn_count_q;
  logic [CNT_W-1:0] err_count_q;

  // Golden result for the incoming command, truncated to the ALU's 5-bit output
  always_comb begin
    product = {4'b0000, cmd_in1} * {4'b0000, cmd_in2};
    golden  = 5'd0;
    unique case (cmd_oper)
      2'b00: golden = {1'b0, cmd_in1} + {1'b0, cmd_in2};
      2'b01: golden = product[4:0];
      2'b10: golden = {1'b0, cmd_in1} - {1'b0, cmd_in2};
      2'b11: golden = (cmd_in2 == 4'd0) ? 5'd0 : {1'b0, cmd_in1 / cmd_in2};
      default: golden = 5'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = StIssue;
        end
      end
      // ALU samples alu_* on the edge leaving this state
      StIssue: state_d = StCapture;
      // ALU result is valid during this state
      StCapture: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU operand registers and golden result, loaded on command accept
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_oper_q     <= 2'd0;
      alu_in1_q      <= 4'd0;
      alu_in2_q      <= 4'd0;
      rsp_expected_q <= 5'd0;
    end else if (accept) begin
      alu_oper_q     <= cmd_oper;
      alu_in1_q      <= cmd_in1;
      alu_in2_q      <= cmd_in2;
      rsp_expected_q <= golden;
    end
  end

  // Result capture; held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q     <= 5'd0;
      rsp_mismatch_q <= 1'b0;
    end else if (capture) begin
      rsp_data_q     <= alu_out;
      rsp_mismatch_q <= (alu_out != rsp_expected_q);
    end
  end

  // Transaction counter wraps; error counter saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_q <= '0;
      err_count_q <= '0;
    end else if (complete) begin
      txn_count_q <= txn_count_q + 1'b1;
      if (rsp_mismatch_q && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign alu_oper     = alu_oper_q;
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_expected = rsp_expected_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign txn_count    = txn_count_q;
  assign err_count    = err_count_q;

endmodule
